uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Synthesizable, parametrised UART receiver with a receive FIFO.
- Successor to the fixed 8N1 UART bus model used in simulation. Adds these at run time: data length 5–8, optional even/odd parity, 1 or 2 stop bits, programmable baud divisor.
- Sits between the uart_rx pad and an APB/stream consumer.
- Reports frame, parity and overrun errors per character and as sticky flags.

Parameters:
- FIFO_DEPTH, 16, number of entries in the RX FIFO; power of 2, ≥ 2.
- OVERSAMPLE, 16, sample ticks per bit; even, ≥ 8.
- DIV_WIDTH, 16, width of the baud divisor input.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- rx_i  in  1  serial input, idle high, asynchronous to clk
- cfg_div_i  in  DIV_WIDTH  clock cycles per sample tick; values 0 and 1 both mean 1
- cfg_bits_i  in  2  data length: 0=5, 1=6, 2=7, 3=8 bits
- cfg_par_en_i  in  1  parity bit present
- cfg_par_odd_i  in  1  1 = odd parity, 0 = even parity
- cfg_stop2_i  in  1  two stop bits expected
- m_data_o  out  8  received character, right-aligned, unused upper bits 0
- m_perr_o  out  1  parity error flag for the head entry
- m_ferr_o  out  1  frame error flag for the head entry
- m_valid_o  out  1  FIFO not empty
- m_ready_i  in  1  consumer accepts the head entry
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current number of entries
- overrun_o  out  1  sticky: a character was dropped because the FIFO was full
- clr_i  in  1  synchronous clear of overrun_o and of the FIFO contents

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, synchronizer flops = 1.
- Input synchronization: rx_i passes through a 2-flop synchronizer; all logic uses the synchronized bit rxs.
- Tick generator: a counter produces a one-cycle tick every max(cfg_div_i, 1) clocks. It runs only while the FSM is outside IDLE and reloads on entry to START.
- Sample counter: counts ticks 0..OVERSAMPLE-1. The mid-bit sample point is count OVERSAMPLE/2-1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE → START on a falling edge of rxs.
  - START: at mid-bit, if rxs=1 it was a glitch → IDLE with nothing pushed; otherwise → DATA at bit end.
  - DATA: samples at mid-bit, LSB first; bit counter runs to cfg_bits_i+4. At the end of the last bit → PARITY if cfg_par_en_i, else STOP1.
  - PARITY: perr = XOR(data bits, parity bit, cfg_par_odd_i).
  - STOP1: at mid-bit, ferr |= ~rxs. Then:
    - if cfg_stop2_i, → STOP2 at bit end;
    - otherwise push the character and → IDLE immediately at mid-bit, so the next start edge is accepted early.
  - STOP2: same check as STOP1, then push and → IDLE.
- Configuration: cfg_* inputs are latched on IDLE→START. A change mid-character affects only the next character.
- FIFO push: the entry is {ferr, perr, data}. m_valid_o rises on the clock edge after the push cycle (1-cycle latency).
- FIFO pop: on m_valid_o & m_ready_i. Data and flags are stable while m_valid_o=1 and m_ready_i=0.
- Simultaneous push and pop on a full FIFO: allowed; no overrun, level unchanged.
- Push when full without a pop: the character is dropped, overrun_o is set, and contents are unchanged.
- Pointers wrap modulo FIFO_DEPTH; the level counter distinguishes full from empty.
- clr_i: empties the FIFO and clears overrun_o in the same cycle. If clr_i and a push coincide, clr_i wins and the character is discarded. The FSM is not affected.
- Reset asserted mid-character aborts immediately. After release the FSM waits for a fresh falling edge, so no partial character is ever pushed.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- Defined: adds output break_o (1 bit), a one-cycle pulse.
  - A character whose data, parity and stop samples are all 0 is a break. It pulses break_o and is not pushed into the FIFO.
  - The FSM then holds in IDLE until rxs has been 1 for one full bit time.
- Undefined: no break_o port. An all-zero character is pushed as data 0 with ferr=1.

Decomposition:
- Package uart_rx_pkg:
  - typedef uart_rx_state_e (the six FSM states);
  - typedef uart_rx_entry_t (struct of ferr, perr, data[7:0]);
  - functions for the bit-count decode and the parity calculation.
- Sub-module uart_rx_sync_fifo: generic synchronous FIFO (DEPTH and entry type parameters, clr input, level output), instantiated once for the RX FIFO.

Test Plan:
- Basic 8N1: clk 25 MHz, cfg_div_i=2, OVERSAMPLE=16 (781250 baud); send 0x65 → m_data_o=0x65, perr=0, ferr=0, m_valid_o high one clock after the STOP1 mid-bit sample.
- 7E2: cfg_bits_i=2, par_en=1, odd=0, stop2=1; send 0x41 with the correct parity bit, then 0x41 with the parity bit flipped → entries {0x41, perr=0} and {0x41, perr=1}.
- Frame error: 8N1 with the stop bit driven 0 and data 0x3C → entry 0x3C with ferr=1. With UART_RX_BREAK_DET_EN and an all-zero frame → break_o pulses and fifo_level_o stays 0.
- Overrun: FIFO_DEPTH=4, m_ready_i=0; send 5 characters 0x01..0x05 → level 4, overrun_o=1, entries 0x01..0x04. Then pulse clr_i → level 0, overrun_o=0.
- Glitch rejection: a 3-tick low pulse on rx_i → FSM returns to IDLE and no push occurs. A start edge arriving during the STOP1 second half of the previous character is received correctly.
- Reset mid-operation: assert rst during DATA bit 3 of 0xA5, release, then send 0x5A → only 0x5A is in the FIFO.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receiver with RX FIFO.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } uart_rx_state_e;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } uart_rx_entry_t;

    // Index of the last data bit: 0..3 selects 5..8 data bits.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] bits);
        return {1'b0, bits} + 3'd4;
    endfunction

    // Unused upper data bits are held at 0, so they do not disturb the XOR.
    function automatic logic parity_err(input logic [7:0] data, input logic par_bit,
                                        input logic odd);
        return (^data) ^ par_bit ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Generic synchronous FIFO with clear and level output.
// clr empties the FIFO and wins over a coincident push or pop.
module uart_rx_sync_fifo #(
    parameter int unsigned DEPTH   = 16,
    parameter type         entry_t = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  entry_t                   wdata,
    input  logic                     pop,
    output entry_t                   rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

    entry_t            mem [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [LvlW-1:0]   level_q;
    logic              wr_en;
    logic              rd_en;

    assign full  = (level_q == LvlFull);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign wr_en = push && !clr && (!full || pop);
    assign rd_en = pop && !empty && !clr;

    // Storage array; no reset needed since the level gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and level bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_q + LvlW'(wr_en) - LvlW'(rd_en);
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (5-8 data bits, optional parity, 1/2 stop bits, programmable
// divisor) feeding a receive FIFO with per-character and sticky error flags.
// Optional build macro UART_RX_BREAK_DET_EN adds break detection and break_o.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_i,
    input  logic [DIV_WIDTH-1:0]          cfg_div_i,
    input  logic [1:0]                    cfg_bits_i,
    input  logic                          cfg_par_en_i,
    input  logic                          cfg_par_odd_i,
    input  logic                          cfg_stop2_i,
    output logic [7:0]                    m_data_o,
    output logic                          m_perr_o,
    output logic                          m_ferr_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overrun_o,
    input  logic                          clr_i
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic                          break_o
`endif
);

    localparam int unsigned SampW = $clog2(OVERSAMPLE);
    localparam logic [SampW-1:0] SampMid  = SampW'(OVERSAMPLE / 2 - 1);
    localparam logic [SampW-1:0] SampLast = SampW'(OVERSAMPLE - 1);

    // Synchronizer and edge history
    logic sync_q, rxs_q, rxs_prev_q;

    // FSM
    uart_rx_state_e state_q, state_d;

    // Configuration latched at the start of each character
    logic [DIV_WIDTH-1:0] div_q;
    logic [1:0]           bits_q;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 stop2_q;

    // Timing and character datapath
    logic [DIV_WIDTH-1:0] tick_cnt_q;
    logic [DIV_WIDTH-1:0] div_m1;
    logic [SampW-1:0]     samp_cnt_q;
    logic [2:0]           bit_idx_q;
    logic [7:0]           data_q;
    logic                 perr_q;
    logic                 ferr_q;

    logic                 tick;
    logic                 mid;
    logic                 bit_end;
    logic                 start_go;
    logic                 frame_done;
    logic                 push;
    uart_rx_entry_t       push_entry;

    // FIFO side
    uart_rx_entry_t       head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 overrun_q;

`ifdef UART_RX_BREAK_DET_EN
    localparam int unsigned HoldW = DIV_WIDTH + SampW + 1;
    logic                 all_zero_q;
    logic                 is_break;
    logic                 break_q;
    logic                 brk_hold_q;
    logic [HoldW-1:0]     hold_cnt_q;
    logic [HoldW-1:0]     bit_cycles_m1;
    logic [DIV_WIDTH-1:0] div_eff;
`endif

    // Two-flop synchronizer plus one history flop for falling-edge detection; idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= rx_i;
            rxs_q      <= sync_q;
            rxs_prev_q <= rxs_q;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    assign start_go = (state_q == StIdle) && rxs_prev_q && !rxs_q && !brk_hold_q;
`else
    assign start_go = (state_q == StIdle) && rxs_prev_q && !rxs_q;
`endif

    // Divisor values 0 and 1 both give a tick every clock.
    assign div_m1  = (div_q <= DIV_WIDTH'(1)) ? '0 : div_q - DIV_WIDTH'(1);
    assign tick    = (state_q != StIdle) && (tick_cnt_q == div_m1);
    assign mid     = tick && (samp_cnt_q == SampMid);
    assign bit_end = tick && (samp_cnt_q == SampLast);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start_go) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (mid && rxs_q) begin
                    state_d = StIdle;
                end else if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end && (bit_idx_q == last_bit_idx(bits_q))) begin
                    state_d = par_en_q ? StParity : StStop1;
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop1;
                end
            end
            StStop1: begin
                // Single stop bit: return at mid-bit so an early next start edge is caught.
                if (mid && !stop2_q) begin
                    state_d = StIdle;
                end else if (bit_end && stop2_q) begin
                    state_d = StStop2;
                end
            end
            StStop2: begin
                if (mid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: completion strobe and the entry to push.
    always_comb begin
        frame_done = mid && (((state_q == StStop1) && !stop2_q) || (state_q == StStop2));
        push_entry.ferr = ferr_q | ~rxs_q;
        push_entry.perr = perr_q;
        push_entry.data = data_q;
`ifdef UART_RX_BREAK_DET_EN
        is_break = frame_done && all_zero_q && !rxs_q;
        push     = frame_done && !is_break;
`else
        push     = frame_done;
`endif
    end

    // Tick/sample counters, latched configuration and character assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            bits_q     <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tick_cnt_q <= '0;
            samp_cnt_q <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            all_zero_q <= 1'b0;
`endif
        end else if (start_go) begin
            div_q      <= cfg_div_i;
            bits_q     <= cfg_bits_i;
            par_en_q   <= cfg_par_en_i;
            par_odd_q  <= cfg_par_odd_i;
            stop2_q    <= cfg_stop2_i;
            tick_cnt_q <= '0;
            samp_cnt_q <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            all_zero_q <= 1'b1;
`endif
        end else if (state_q != StIdle) begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            if (tick) begin
                samp_cnt_q <= (samp_cnt_q == SampLast) ? '0 : samp_cnt_q + 1'b1;
            end
            if (mid) begin
                case (state_q)
                    StData:            data_q[bit_idx_q] <= rxs_q;
                    StParity:          perr_q <= parity_err(data_q, rxs_q, par_odd_q);
                    StStop1, StStop2:  ferr_q <= ferr_q | ~rxs_q;
                    default: ;
                endcase
`ifdef UART_RX_BREAK_DET_EN
                if (state_q != StStart && rxs_q) begin
                    all_zero_q <= 1'b0;
                end
`endif
            end
            if (bit_end && (state_q == StData) && (bit_idx_q != last_bit_idx(bits_q))) begin
                bit_idx_q <= bit_idx_q + 1'b1;
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    assign div_eff       = (div_q <= DIV_WIDTH'(1)) ? DIV_WIDTH'(1) : div_q;
    assign bit_cycles_m1 = HoldW'(div_eff) * HoldW'(OVERSAMPLE) - HoldW'(1);

    // Break pulse, then block new starts until the line has been high for a full bit time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            break_q    <= 1'b0;
            brk_hold_q <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            break_q <= is_break;
            if (is_break) begin
                brk_hold_q <= 1'b1;
                hold_cnt_q <= '0;
            end else if (brk_hold_q) begin
                if (!rxs_q) begin
                    hold_cnt_q <= '0;
                end else if (hold_cnt_q == bit_cycles_m1) begin
                    brk_hold_q <= 1'b0;
                end else begin
                    hold_cnt_q <= hold_cnt_q + 1'b1;
                end
            end
        end
    end

    assign break_o = break_q;
`endif

    assign pop = m_valid_o && m_ready_i;

    uart_rx_sync_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (uart_rx_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_i),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level_o)
    );

    // Sticky overrun: a completed character found the FIFO full with no pop to make room.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (clr_i) begin
            overrun_q <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun_o = overrun_q;
    assign m_valid_o = !fifo_empty;
    assign m_data_o  = m_valid_o ? head.data : 8'h00;
    assign m_perr_o  = m_valid_o && head.perr;
    assign m_ferr_o  = m_valid_o && head.ferr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus pushes expected {ferr, perr, data}
// entries, a monitor pops and compares on every accepted FIFO output.
module tb_uart_rx_fifo;

    localparam int DEPTH = 4;
    localparam int OS    = 16;
    localparam int DW    = 16;
    localparam int DIV   = 2;
    localparam int BIT   = DIV * OS;

    logic          clk;
    logic          rst;
    logic          rx;
    logic [DW-1:0] cfg_div;
    logic [1:0]    cfg_bits;
    logic          cfg_par_en;
    logic          cfg_par_odd;
    logic          cfg_stop2;
    logic [7:0]    m_data;
    logic          m_perr;
    logic          m_ferr;
    logic          m_valid;
    logic          m_ready;
    logic [2:0]    fifo_level;
    logic          overrun;
    logic          clr;
`ifdef UART_RX_BREAK_DET_EN
    logic          brk;
    int            brk_cnt = 0;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [9:0]    exp_q[$];

    uart_rx_fifo #(
        .FIFO_DEPTH (DEPTH),
        .OVERSAMPLE (OS),
        .DIV_WIDTH  (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_i          (rx),
        .cfg_div_i     (cfg_div),
        .cfg_bits_i    (cfg_bits),
        .cfg_par_en_i  (cfg_par_en),
        .cfg_par_odd_i (cfg_par_odd),
        .cfg_stop2_i   (cfg_stop2),
        .m_data_o      (m_data),
        .m_perr_o      (m_perr),
        .m_ferr_o      (m_ferr),
        .m_valid_o     (m_valid),
        .m_ready_i     (m_ready),
        .fifo_level_o  (fifo_level),
        .overrun_o     (overrun),
        .clr_i         (clr)
`ifdef UART_RX_BREAK_DET_EN
        ,
        .break_o       (brk)
`endif
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Monitor: every accepted head entry must match the oldest expectation.
    always @(negedge clk) begin
        logic [9:0] got;
        logic [9:0] exp;
        if (!rst && m_valid && m_ready) begin
            got = {m_ferr, m_perr, m_data};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_entry got %03h required none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL entry got %03h required %03h", got, exp);
                end
            end
        end
`ifdef UART_RX_BREAK_DET_EN
        if (brk) brk_cnt++;
`endif
    end

    initial begin
        #2400000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [1:0] bits, input logic pen, input logic odd,
                           input logic stop2);
        cfg_bits    = bits;
        cfg_par_en  = pen;
        cfg_par_odd = odd;
        cfg_stop2   = stop2;
    endtask

    // Drives one frame LSB first; last_stop sets the duration of the final stop bit.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen,
                              input bit odd, input bit flip, input bit two_stop,
                              input logic stop_val, input int last_stop, input int idle);
        logic p;
        p = (^d) ^ odd ^ flip;
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < nbits; i++) begin
            rx = d[i];
            wait_clk(BIT);
        end
        if (pen) begin
            rx = p;
            wait_clk(BIT);
        end
        if (two_stop) begin
            rx = stop_val;
            wait_clk(BIT);
        end
        rx = stop_val;
        wait_clk(last_stop);
        rx = 1'b1;
        wait_clk(idle);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_clk(1);
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        cfg_div = DW'(DIV);
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        m_ready = 1'b1;
        clr = 1'b0;
        wait_clk(3);
        check("reset_level", 32'(fifo_level), 0);
        check("reset_valid", 32'(m_valid), 0);
        check("reset_overrun", 32'(overrun), 0);
        check("reset_data", 32'({m_ferr, m_perr, m_data}), 0);
        rst = 1'b0;
        wait_clk(BIT);

        // 8N1 basic
        exp_q.push_back({2'b00, 8'h65});
        send_frame(8'h65, 8, 0, 0, 0, 0, 1'b1, BIT, 2 * BIT);

        // 7E2: correct parity then flipped parity
        set_cfg(2'd2, 1'b1, 1'b0, 1'b1);
        exp_q.push_back({2'b00, 8'h41});
        send_frame(8'h41, 7, 1, 0, 0, 1, 1'b1, BIT, 2 * BIT);
        exp_q.push_back({2'b01, 8'h41});
        send_frame(8'h41, 7, 1, 0, 1, 1, 1'b1, BIT, 2 * BIT);

        // 5O1 and 6N1
        set_cfg(2'd0, 1'b1, 1'b1, 1'b0);
        exp_q.push_back({2'b00, 8'h15});
        send_frame(8'h15, 5, 1, 1, 0, 0, 1'b1, BIT, 2 * BIT);
        set_cfg(2'd1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({2'b00, 8'h2A});
        send_frame(8'h2A, 6, 0, 0, 0, 0, 1'b1, BIT, 2 * BIT);

        // Frame error: 8N1, stop bit low
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({2'b10, 8'h3C});
        send_frame(8'h3C, 8, 0, 0, 0, 0, 1'b0, BIT, 2 * BIT);
        wait_drain();

        // All-zero frame: break when enabled, otherwise data 0 with ferr
`ifdef UART_RX_BREAK_DET_EN
        send_frame(8'h00, 8, 0, 0, 0, 0, 1'b0, BIT, 3 * BIT);
        check("break_pulses", 32'(brk_cnt), 1);
        check("break_level", 32'(fifo_level), 0);
`else
        exp_q.push_back({2'b10, 8'h00});
        send_frame(8'h00, 8, 0, 0, 0, 0, 1'b0, BIT, 3 * BIT);
`endif
        wait_drain();

        // Glitch: 3-tick low pulse must not produce a character
        rx = 1'b0;
        wait_clk(3 * DIV);
        rx = 1'b1;
        wait_clk(2 * BIT);
        check("glitch_level", 32'(fifo_level), 0);
        check("glitch_valid", 32'(m_valid), 0);

        // Next start edge inside the second half of the previous stop bit
        exp_q.push_back({2'b00, 8'h81});
        send_frame(8'h81, 8, 0, 0, 0, 0, 1'b1, (3 * BIT) / 4, 0);
        exp_q.push_back({2'b00, 8'h7E});
        send_frame(8'h7E, 8, 0, 0, 0, 0, 1'b1, BIT, 2 * BIT);
        wait_drain();

        // Overrun: five characters into a four-entry FIFO with no consumer
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back({2'b00, 8'(i)});
            send_frame(8'(i), 8, 0, 0, 0, 0, 1'b1, BIT, BIT);
        end
        check("ovr_level", 32'(fifo_level), 4);
        check("ovr_flag", 32'(overrun), 1);
        check("ovr_head_stable", 32'(m_data), 32'h01);
        m_ready = 1'b1;
        wait_drain();
        wait_clk(2);
        check("ovr_drained", 32'(fifo_level), 0);
        check("ovr_sticky", 32'(overrun), 1);
        clr = 1'b1;
        wait_clk(1);
        clr = 1'b0;
        check("clr_overrun", 32'(overrun), 0);

        // clr empties queued contents
        m_ready = 1'b0;
        send_frame(8'h11, 8, 0, 0, 0, 0, 1'b1, BIT, BIT);
        send_frame(8'h22, 8, 0, 0, 0, 0, 1'b1, BIT, BIT);
        check("clr_pre_level", 32'(fifo_level), 2);
        clr = 1'b1;
        wait_clk(1);
        clr = 1'b0;
        check("clr_level", 32'(fifo_level), 0);
        check("clr_valid", 32'(m_valid), 0);
        m_ready = 1'b1;

        // Reset during data bit 3 of 0xA5 (bits LSB first: 1,0,1,0)
        rx = 1'b0;
        wait_clk(BIT);
        rx = 1'b1;
        wait_clk(BIT);
        rx = 1'b0;
        wait_clk(BIT);
        rx = 1'b1;
        wait_clk(BIT);
        rx = 1'b0;
        wait_clk(BIT / 2);
        rst = 1'b1;
        rx = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(BIT);
        check("rst_mid_level", 32'(fifo_level), 0);
        exp_q.push_back({2'b00, 8'h5A});
        send_frame(8'h5A, 8, 0, 0, 0, 0, 1'b1, BIT, 2 * BIT);
        wait_drain();

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
